eq_quant_coeff_loader: RTL and testbench

//  Downstream consumer of the EQ quant0 address/control software register and the companion coefficient register.
//  On a software commit edge it writes one coefficient into the EQ coefficient BRAM.

---
 rtl/eq_quant_coeff_loader_if.sv | 35 +++
 rtl/eq_quant_coeff_loader.sv | 130 +++++++++++++
 tb/tb_eq_quant_coeff_loader.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_quant_coeff_loader_if.sv
// Bus bundle between the EQ quant0 register outputs and the coefficient RAM write port.
// The cksum signal exists only when EQ_COEFF_CKSUM_EN is defined.
interface eq_quant_coeff_loader_if #(
    parameter int ADDR_W = 10,
    parameter int COEF_W = 16
);
    logic [31:0]       ctrl_reg;
    logic [31:0]       coef_reg;
    logic [ADDR_W-1:0] bram_addr;
    logic [COEF_W-1:0] bram_din;
    logic              bram_we;
    logic              busy;
    logic              done_pulse;
    logic [15:0]       done_cnt;
    logic              err_ovr;
`ifdef EQ_COEFF_CKSUM_EN
    logic [31:0]       cksum;
`endif

    modport slave (
        input  ctrl_reg, coef_reg,
        output bram_addr, bram_din, bram_we, busy, done_pulse, done_cnt, err_ovr
`ifdef EQ_COEFF_CKSUM_EN
        , output cksum
`endif
    );

    modport master (
        output ctrl_reg, coef_reg,
        input  bram_addr, bram_din, bram_we, busy, done_pulse, done_cnt, err_ovr
`ifdef EQ_COEFF_CKSUM_EN
        , input cksum
`endif
    );
endinterface

// File: rtl/eq_quant_coeff_loader.sv
// Writes committed EQ coefficients (single or wrapping burst) into the coefficient RAM.
// Define EQ_COEFF_CKSUM_EN to add a running checksum of written words.
//
// state   | meaning
// IDLE    | waiting for a commit edge
// WRITE   | one RAM write per cycle, remaining count in rem_q
// DONE    | sequence finished, done_pulse high, back to IDLE next cycle
module eq_quant_coeff_loader #(
    parameter int ADDR_W = 10,
    parameter int COEF_W = 16
) (
    input  logic                     user_clk,
    input  logic                     user_rst,
    eq_quant_coeff_loader_if.slave   loader
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              commit_q, commit_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [COEF_W-1:0] din_q, din_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_pulse_q, done_pulse_d;
    logic [15:0]       done_cnt_q, done_cnt_d;
    logic              err_ovr_q, err_ovr_d;
    logic              commit_edge;

    assign commit_edge = loader.ctrl_reg[31] & ~commit_q;

    always_comb begin
        state_d      = state_q;
        commit_d     = loader.ctrl_reg[31];
        rem_d        = rem_q;
        addr_d       = addr_q;
        din_d        = din_q;
        we_d         = we_q;
        busy_d       = busy_q;
        done_pulse_d = 1'b0;
        done_cnt_d   = done_cnt_q;
        err_ovr_d    = err_ovr_q;
        case (state_q)
            S_IDLE: begin
                if (commit_edge) begin
                    state_d = S_WRITE;
                    addr_d  = loader.ctrl_reg[ADDR_W-1:0];
                    rem_d   = loader.ctrl_reg[16 +: ADDR_W];
                    din_d   = loader.coef_reg[COEF_W-1:0];
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_WRITE: begin
                if (commit_edge) err_ovr_d = 1'b1;
                if (rem_q == '0) begin
                    state_d      = S_DONE;
                    we_d         = 1'b0;
                    done_pulse_d = 1'b1;
                    done_cnt_d   = done_cnt_q + 16'd1;
                end else begin
                    rem_d  = rem_q - ADDR_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_DONE: begin
                if (commit_edge) err_ovr_d = 1'b1;
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                we_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // commit_q resets high so a commit held through reset is not seen as an edge
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q      <= S_IDLE;
            commit_q     <= 1'b1;
            rem_q        <= '0;
            addr_q       <= '0;
            din_q        <= '0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_pulse_q <= 1'b0;
            done_cnt_q   <= '0;
            err_ovr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            commit_q     <= commit_d;
            rem_q        <= rem_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            we_q         <= we_d;
            busy_q       <= busy_d;
            done_pulse_q <= done_pulse_d;
            done_cnt_q   <= done_cnt_d;
            err_ovr_q    <= err_ovr_d;
        end
    end

`ifdef EQ_COEFF_CKSUM_EN
    logic [31:0] cksum_q, cksum_d;

    assign cksum_d = we_q ? (cksum_q + 32'(din_q)) : cksum_q;

    always_ff @(posedge user_clk) begin
        if (user_rst) cksum_q <= '0;
        else          cksum_q <= cksum_d;
    end

    assign loader.cksum = cksum_q;
`endif

    assign loader.bram_addr  = addr_q;
    assign loader.bram_din   = din_q;
    assign loader.bram_we    = we_q;
    assign loader.busy       = busy_q;
    assign loader.done_pulse = done_pulse_q;
    assign loader.done_cnt   = done_cnt_q;
    assign loader.err_ovr    = err_ovr_q;

    wire unused_ok = &{1'b0, loader.ctrl_reg, loader.coef_reg};
endmodule

// File: tb/tb_eq_quant_coeff_loader.sv
// Directed self-checking bench for eq_quant_coeff_loader.
// Define EQ_COEFF_CKSUM_EN to also exercise the checksum.
module tb_eq_quant_coeff_loader;
    logic user_clk = 1'b0;
    logic user_rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    eq_quant_coeff_loader_if #(.ADDR_W(10), .COEF_W(16)) bus_if ();

    eq_quant_coeff_loader #(.ADDR_W(10), .COEF_W(16)) dut (
        .user_clk (user_clk),
        .user_rst (user_rst),
        .loader   (bus_if.slave)
    );

    always #5 user_clk = ~user_clk;

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic test_reset();
        user_rst = 1'b1;
        bus_if.ctrl_reg = 32'h8000_0000;
        bus_if.coef_reg = 32'h0000_ABCD;
        tick(); tick();
        n_cmp++;
        if (bus_if.bram_we !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.done_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got we=%b busy=%b dp=%b expected 0 0 0",
                     bus_if.bram_we, bus_if.busy, bus_if.done_pulse);
        end
        n_cmp++;
        if (bus_if.bram_addr !== 10'h000 || bus_if.bram_din !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_data: got addr=%h din=%h expected 000 0000", bus_if.bram_addr, bus_if.bram_din);
        end
        n_cmp++;
        if (bus_if.done_cnt !== 16'h0000 || bus_if.err_ovr !== 1'b0) begin
            n_err++;
            $display("FAIL reset_status: got cnt=%h err=%b expected 0000 0", bus_if.done_cnt, bus_if.err_ovr);
        end
        user_rst = 1'b0;
        begin
            int nwe = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (bus_if.bram_we === 1'b1) nwe++;
            end
            n_cmp++;
            if (nwe != 0) begin
                n_err++;
                $display("FAIL reset_held_commit: got %0d writes expected 0", nwe);
            end
        end
        bus_if.ctrl_reg = 32'h0;
        tick();
    endtask

    task automatic test_single();
        bus_if.ctrl_reg = 32'h0000_0005;
        bus_if.coef_reg = 32'h0000_1234;
        tick();
        bus_if.ctrl_reg = 32'h8000_0005;
        tick();
        n_cmp++;
        if (bus_if.bram_we !== 1'b1 || bus_if.bram_addr !== 10'h005 || bus_if.bram_din !== 16'h1234) begin
            n_err++;
            $display("FAIL single_write: got we=%b addr=%h din=%h expected 1 005 1234",
                     bus_if.bram_we, bus_if.bram_addr, bus_if.bram_din);
        end
        n_cmp++;
        if (bus_if.busy !== 1'b1 || bus_if.done_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL single_busy: got busy=%b dp=%b expected 1 0", bus_if.busy, bus_if.done_pulse);
        end
        tick();
        n_cmp++;
        if (bus_if.bram_we !== 1'b0 || bus_if.done_pulse !== 1'b1 || bus_if.busy !== 1'b1 ||
            bus_if.done_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL single_done: got we=%b dp=%b busy=%b cnt=%h expected 0 1 1 0001",
                     bus_if.bram_we, bus_if.done_pulse, bus_if.busy, bus_if.done_cnt);
        end
        tick();
        n_cmp++;
        if (bus_if.done_pulse !== 1'b0 || bus_if.busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle: got dp=%b busy=%b expected 0 0", bus_if.done_pulse, bus_if.busy);
        end
        bus_if.ctrl_reg = 32'h0;
        tick();
    endtask

    task automatic test_burst_wrap();
        logic [9:0] exp_a [4];
        int nwe = 0;
        int nbusy = 0;
        exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        bus_if.coef_reg = 32'h0000_BEEF;
        bus_if.ctrl_reg = 32'h8003_03FE;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_if.busy === 1'b1) nbusy++;
            if (bus_if.bram_we === 1'b1) begin
                if (nwe < 4) begin
                    n_cmp++;
                    if (bus_if.bram_addr !== exp_a[nwe] || bus_if.bram_din !== 16'hBEEF) begin
                        n_err++;
                        $display("FAIL burst_addr%0d: got addr=%h din=%h expected %h BEEF",
                                 nwe, bus_if.bram_addr, bus_if.bram_din, exp_a[nwe]);
                    end
                end
                nwe++;
            end
        end
        n_cmp++;
        if (nwe != 4 || nbusy != 5) begin
            n_err++;
            $display("FAIL burst_counts: got writes=%0d busy=%0d expected 4 5", nwe, nbusy);
        end
        n_cmp++;
        if (bus_if.done_cnt !== 16'd2 || bus_if.err_ovr !== 1'b0) begin
            n_err++;
            $display("FAIL burst_status: got cnt=%h err=%b expected 0002 0", bus_if.done_cnt, bus_if.err_ovr);
        end
        bus_if.ctrl_reg = 32'h0;
        tick();
    endtask

    task automatic test_overrun();
        int nwe = 0;
        int ndp = 0;
        bus_if.coef_reg = 32'h0000_55AA;
        bus_if.ctrl_reg = 32'h8007_0010;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (bus_if.bram_we === 1'b1) nwe++;
            if (bus_if.done_pulse === 1'b1) ndp++;
            if (i == 1) bus_if.ctrl_reg = 32'h0007_0010;
            if (i == 2) bus_if.ctrl_reg = 32'h8007_0010;
        end
        n_cmp++;
        if (nwe != 8 || ndp != 1) begin
            n_err++;
            $display("FAIL overrun_counts: got writes=%0d done=%0d expected 8 1", nwe, ndp);
        end
        n_cmp++;
        if (bus_if.err_ovr !== 1'b1 || bus_if.done_cnt !== 16'd3 || bus_if.busy !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_status: got err=%b cnt=%h busy=%b expected 1 0003 0",
                     bus_if.err_ovr, bus_if.done_cnt, bus_if.busy);
        end
        bus_if.ctrl_reg = 32'h0;
        tick(); tick();
        n_cmp++;
        if (bus_if.err_ovr !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_sticky: got %b expected 1", bus_if.err_ovr);
        end
    endtask

    task automatic test_reset_mid();
        int nwe = 0;
        bus_if.coef_reg = 32'h0000_0C0C;
        bus_if.ctrl_reg = 32'h8007_0020;
        tick(); tick(); tick();
        n_cmp++;
        if (bus_if.bram_we !== 1'b1 || bus_if.bram_addr !== 10'h022) begin
            n_err++;
            $display("FAIL rstmid_third: got we=%b addr=%h expected 1 022", bus_if.bram_we, bus_if.bram_addr);
        end
        user_rst = 1'b1;
        tick();
        n_cmp++;
        if (bus_if.bram_we !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.done_cnt !== 16'd0 ||
            bus_if.err_ovr !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_cleared: got we=%b busy=%b cnt=%h err=%b expected 0 0 0000 0",
                     bus_if.bram_we, bus_if.busy, bus_if.done_cnt, bus_if.err_ovr);
        end
        user_rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus_if.bram_we === 1'b1) nwe++;
        end
        n_cmp++;
        if (nwe != 0) begin
            n_err++;
            $display("FAIL rstmid_no_resume: got %0d writes expected 0", nwe);
        end
        bus_if.ctrl_reg = 32'h0007_0020;
        tick();
        bus_if.ctrl_reg = 32'h8007_0020;
        nwe = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus_if.bram_we === 1'b1) nwe++;
        end
        n_cmp++;
        if (nwe != 8 || bus_if.done_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL rstmid_restart: got writes=%0d cnt=%h expected 8 0001", nwe, bus_if.done_cnt);
        end
        bus_if.ctrl_reg = 32'h0;
        tick();
    endtask

    task automatic test_held_commit();
        int nwe = 0;
        int ndp = 0;
        logic [9:0] last_a = 10'h000;
        bus_if.coef_reg = 32'h0000_0F0F;
        bus_if.ctrl_reg = 32'h8000_0100;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus_if.bram_we === 1'b1) begin
                nwe++;
                last_a = bus_if.bram_addr;
            end
            if (bus_if.done_pulse === 1'b1) ndp++;
        end
        n_cmp++;
        if (nwe != 1 || ndp != 1 || last_a !== 10'h100) begin
            n_err++;
            $display("FAIL held_commit: got writes=%0d done=%0d addr=%h expected 1 1 100", nwe, ndp, last_a);
        end
        n_cmp++;
        if (bus_if.done_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL held_cnt: got %h expected 0002", bus_if.done_cnt);
        end
        bus_if.ctrl_reg = 32'h0;
        tick();
    endtask

`ifdef EQ_COEFF_CKSUM_EN
    task automatic test_cksum();
        user_rst = 1'b1;
        tick();
        user_rst = 1'b0;
        tick();
        n_cmp++;
        if (bus_if.cksum !== 32'h0) begin
            n_err++;
            $display("FAIL cksum_reset: got %h expected 00000000", bus_if.cksum);
        end
        bus_if.coef_reg = 32'h0000_FFFF;
        bus_if.ctrl_reg = 32'h8003_0000;
        for (int i = 0; i < 10; i++) tick();
        bus_if.ctrl_reg = 32'h0;
        tick();
        bus_if.coef_reg = 32'h0000_0001;
        bus_if.ctrl_reg = 32'h8000_0000;
        for (int i = 0; i < 6; i++) tick();
        n_cmp++;
        if (bus_if.cksum !== 32'h0003_FFFD) begin
            n_err++;
            $display("FAIL cksum_sum: got %h expected 0003fffd", bus_if.cksum);
        end
        bus_if.ctrl_reg = 32'h0;
        tick();
    endtask
`endif

    initial begin
        bus_if.ctrl_reg = 32'h0;
        bus_if.coef_reg = 32'h0;
        test_reset();
        test_single();
        test_burst_wrap();
        test_overrun();
        test_reset_mid();
        test_held_commit();
`ifdef EQ_COEFF_CKSUM_EN
        test_cksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
